// File: rtl/ad_jesd_rx_deframer.sv
// ----------------------------------------------------------------------------
// ad_jesd_rx_deframer
//
// JESD204 RX transport-layer deframer. It takes the link-layer beat stream
// (NUM_LANES lanes x 4 octets per beat) and produces per-channel ADC samples.
// The first beat that carries a start-of-frame marker fixes the octet offset
// within a beat. Each output word is built from the previous accepted beat
// and the current one, so it appears one beat late. A later beat whose SOF
// mask differs from the locked pattern drops the lock.
//
// Optional feature (macro AD_JESD_RX_FRAME_ERR_CNT_EN):
//   defined     -> adc_frame_err_cnt counts SOF mismatches and saturates at
//                  16'hFFFF. Only adc_rst clears it.
//   not defined -> no counter; adc_frame_err_cnt is tied to 16'd0.
//
// Ports
//   adc_clk            in   clock (link clock), rising edge
//   adc_rst            in   synchronous reset, active-high
//   rx_valid           in   link beat valid
//   rx_sof             in   [3:0] frame-start octet mask within the beat
//   rx_data            in   [32*NUM_LANES-1:0] lane l at [32l+31:32l]
//   rx_ready           out  always 1
//   adc_valid          out  qualifies adc_data / adc_or
//   adc_data           out  [32*NUM_LANES-1:0] channel c at [c*W+W-1:c*W]
//   adc_or             out  [NUM_CHANNELS-1:0] per-channel over-range
//   adc_status         out  1 while locked
//   adc_frame_err_cnt  out  [15:0] SOF mismatch count
// ----------------------------------------------------------------------------
module ad_jesd_rx_deframer #(
    parameter int NUM_LANES            = 2,
    parameter int NUM_CHANNELS         = 2,
    parameter int CONVERTER_RESOLUTION = 16
) (
    input  logic                       adc_clk,
    input  logic                       adc_rst,
    input  logic                       rx_valid,
    input  logic [3:0]                 rx_sof,
    input  logic [32*NUM_LANES-1:0]    rx_data,
    output logic                       rx_ready,
    output logic                       adc_valid,
    output logic [32*NUM_LANES-1:0]    adc_data,
    output logic [NUM_CHANNELS-1:0]    adc_or,
    output logic                       adc_status,
    output logic [15:0]                adc_frame_err_cnt
);

    localparam int DW          = 32 * NUM_LANES;
    localparam int NUM_SAMPLES = 2 * NUM_LANES;
    localparam int SPC         = NUM_SAMPLES / NUM_CHANNELS;
    localparam int CTRL_BITS   = 16 - CONVERTER_RESOLUTION;
    // The low CTRL_BITS bits of each sample carry control information, not data.
    localparam logic [15:0] DATA_MASK = 16'hFFFF << CTRL_BITS;

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic           lock_s;
    logic           accept_s;
    logic [1:0]     off_r;
    logic [3:0]     pat_r;
    logic [DW-1:0]  prev_r;
    logic [31:0]    aligned_s [NUM_LANES];
    logic [DW-1:0]  samp_data_s;
    logic [NUM_CHANNELS-1:0] samp_or_s;

    // Return the index of the lowest set bit. The caller guarantees that the mask is non-zero.
    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        logic [1:0] idx;
        if (mask[0]) begin
            idx = 2'd0;
        end else if (mask[1]) begin
            idx = 2'd1;
        end else if (mask[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Octet i of the result is octet (i+off) of the 8-octet window {cur, prev}.
    function automatic logic [31:0] align_lane(input logic [31:0] prev,
                                               input logic [31:0] cur,
                                               input logic [1:0]  off);
        logic [63:0] window;
        window = {cur, prev} >> {off, 3'b000};
        return window[31:0];
    endfunction

    assign rx_ready = 1'b1;

    // FSM state register
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_r <= ST_WAIT_SOF;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and beat classification (lock / accept)
    always_comb begin
        state_s  = state_r;
        lock_s   = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_WAIT_SOF: begin
                if (rx_valid && (rx_sof != 4'd0)) begin
                    lock_s  = 1'b1;
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_WAIT_SOF;
                end
            end
            ST_LOCKED: begin
                if (rx_valid) begin
                    if ((rx_sof == 4'd0) || (rx_sof == pat_r)) begin
                        accept_s = 1'b1;
                        state_s  = ST_LOCKED;
                    end else begin
                        // Pattern mismatch: discard the beat. Relock is only possible from the next beat.
                        state_s = ST_WAIT_SOF;
                    end
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s = ST_WAIT_SOF;
            end
        endcase
    end

    // Store the lock offset/pattern and the last accepted beat
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            off_r  <= 2'd0;
            pat_r  <= 4'd0;
            prev_r <= '0;
        end else begin
            if (lock_s) begin
                off_r <= lowest_set(rx_sof);
                pat_r <= rx_sof;
            end
            if (lock_s || accept_s) begin
                prev_r <= rx_data;
            end
        end
    end

    // Align each lane across the previous and current beats
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            aligned_s[l] = align_lane(prev_r[32*l +: 32], rx_data[32*l +: 32], off_r);
        end
    end

    // Map aligned octets to samples, mask the control bits, and collect the over-range flags.
    // Global sample g always lands at bits [16g+15:16g] because W = 16*SPC.
    always_comb begin
        samp_data_s = '0;
        samp_or_s   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            samp_data_s[32*l      +: 16] = {aligned_s[l][7:0],   aligned_s[l][15:8]}  & DATA_MASK;
            samp_data_s[32*l + 16 +: 16] = {aligned_s[l][23:16], aligned_s[l][31:24]} & DATA_MASK;
            if (CONVERTER_RESOLUTION < 16) begin
                samp_or_s[(2*l)/SPC]   = samp_or_s[(2*l)/SPC]   | aligned_s[l][8];
                samp_or_s[(2*l+1)/SPC] = samp_or_s[(2*l+1)/SPC] | aligned_s[l][24];
            end else begin
                samp_or_s = '0;
            end
        end
    end

    // Registered sample outputs and lock status. The data registers hold their value between accepted beats.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            adc_valid  <= 1'b0;
            adc_data   <= '0;
            adc_or     <= '0;
            adc_status <= 1'b0;
        end else begin
            adc_valid  <= accept_s;
            adc_status <= (state_s == ST_LOCKED);
            if (accept_s) begin
                adc_data <= samp_data_s;
                adc_or   <= samp_or_s;
            end
        end
    end

`ifdef AD_JESD_RX_FRAME_ERR_CNT_EN
    logic        mismatch_s;
    logic [15:0] err_cnt_r;

    assign mismatch_s = (state_r == ST_LOCKED) && rx_valid &&
                        (rx_sof != 4'd0) && (rx_sof != pat_r);

    // Saturating SOF mismatch counter
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            err_cnt_r <= 16'd0;
        end else if (mismatch_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign adc_frame_err_cnt = err_cnt_r;
`else
    assign adc_frame_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ad_jesd_rx_deframer.sv
// Two deframers are driven with the same beat stream:
//   dut_a: 2 lanes, 2 channels, 16-bit resolution (no masking, adc_or stays 0)
//   dut_b: 2 lanes, 4 channels, 14-bit resolution (low 2 bits masked, per-sample over-range)
// Expected output words are hand-computed and pushed to a queue when the completing beat is issued.
// A monitor pops an entry and compares it whenever either DUT raises adc_valid.
module tb_ad_jesd_rx_deframer;

`ifdef AD_JESD_RX_FRAME_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [3:0]  rx_sof;
    logic [63:0] rx_data;

    logic        rx_ready_a, adc_valid_a, adc_status_a;
    logic [63:0] adc_data_a;
    logic [1:0]  adc_or_a;
    logic [15:0] err_cnt_a;
    logic        rx_ready_b, adc_valid_b, adc_status_b;
    logic [63:0] adc_data_b;
    logic [3:0]  adc_or_b;
    logic [15:0] err_cnt_b;

    typedef struct {
        logic [63:0] da;
        logic [63:0] db;
        logic [3:0]  ob;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ad_jesd_rx_deframer #(.NUM_LANES(2), .NUM_CHANNELS(2), .CONVERTER_RESOLUTION(16)) dut_a (
        .adc_clk(clk), .adc_rst(rst), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_data(rx_data),
        .rx_ready(rx_ready_a), .adc_valid(adc_valid_a), .adc_data(adc_data_a), .adc_or(adc_or_a),
        .adc_status(adc_status_a), .adc_frame_err_cnt(err_cnt_a));

    ad_jesd_rx_deframer #(.NUM_LANES(2), .NUM_CHANNELS(4), .CONVERTER_RESOLUTION(14)) dut_b (
        .adc_clk(clk), .adc_rst(rst), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_data(rx_data),
        .rx_ready(rx_ready_b), .adc_valid(adc_valid_b), .adc_data(adc_data_b), .adc_or(adc_or_b),
        .adc_status(adc_status_b), .adc_frame_err_cnt(err_cnt_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [63:0] da, input logic [63:0] db, input logic [3:0] ob);
        exp_t e;
        e.da = da;
        e.db = db;
        e.ob = ob;
        exp_q.push_back(e);
    endtask

    // Drive one beat, let it be sampled, and return 1 time unit after the edge.
    task automatic beat(input logic v, input logic [3:0] s, input logic [63:0] d);
        rx_valid = v;
        rx_sof   = s;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lock(input string name, input logic st, input logic [15:0] cnt);
        check({name, "_status_a"}, 64'(adc_status_a), 64'(st));
        check({name, "_status_b"}, 64'(adc_status_b), 64'(st));
        check({name, "_cnt_a"}, 64'(err_cnt_a), CNT_ON ? 64'(cnt) : 64'd0);
        check({name, "_cnt_b"}, 64'(err_cnt_b), CNT_ON ? 64'(cnt) : 64'd0);
    endtask

    // Monitor: compare every presented output word against the next expected entry
    always @(negedge clk) begin
        if (adc_valid_a || adc_valid_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid a=%0b b=%0b, expected none", adc_valid_a, adc_valid_b);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_a", 64'(adc_valid_a), 64'd1);
                check("valid_b", 64'(adc_valid_b), 64'd1);
                check("data_a", adc_data_a, e.da);
                check("or_a", 64'(adc_or_a), 64'd0);
                check("data_b", adc_data_b, e.db);
                check("or_b", 64'(adc_or_b), 64'(e.ob));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_sof   = 4'd0;
        rx_data  = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_data_a", adc_data_a, 64'd0);
        check("reset_data_b", adc_data_b, 64'd0);
        check("reset_or_b", 64'(adc_or_b), 64'd0);
        check("rx_ready_a", 64'(rx_ready_a), 64'd1);
        check("rx_ready_b", 64'(rx_ready_b), 64'd1);
        check_lock("reset", 1'b0, 16'd0);

        // Beats with no SOF or no valid are ignored while waiting for SOF
        beat(1'b1, 4'b0000, 64'hDEAD_BEEF_0BAD_F00D);
        beat(1'b0, 4'b0001, 64'hDEAD_BEEF_0BAD_F00D);
        check_lock("wait_ignore", 1'b0, 16'd0);

        // Offset 0, back-to-back beats
        beat(1'b1, 4'b0001, 64'h1312_1110_0302_0100);
        check_lock("lock_off0", 1'b1, 16'd0);
        push(64'h1213_1011_0203_0001, 64'h1210_1010_0200_0000, 4'b1111);
        beat(1'b1, 4'b0001, 64'h1716_1514_0706_0504);
        push(64'h1617_1415_0607_0405, 64'h1614_1414_0604_0404, 4'b1111);
        beat(1'b1, 4'b0001, 64'h1B1A_1918_0B0A_0908);
        push(64'h1A1B_1819_0A0B_0809, 64'h1A18_1818_0A08_0808, 4'b1111);
        beat(1'b1, 4'b0001, 64'h1F1E_1D1C_0F0E_0D0C);
        beat(1'b0, 4'b0000, 64'd0);

        // Mismatch (sof 0100 against pattern 0001)
        beat(1'b1, 4'b0100, 64'h5555_5555_5555_5555);
        check_lock("mismatch1", 1'b0, 16'd1);

        // Offset 2 lock; then a beat that completes lane words across two beats
        beat(1'b1, 4'b0100, 64'h9392_9190_3322_1100);
        check_lock("lock_off2", 1'b1, 16'd1);
        push(64'h9495_9293_4455_2233, 64'h9494_9290_4454_2230, 4'b1111);
        beat(1'b1, 4'b0100, 64'h9796_9594_7766_5544);
        // Samples ABCD / ABCE (over-range bit set / clear)
        push(64'hABCE_9697_ABCD_6677, 64'hABCC_9694_ABCC_6674, 4'b0111);
        beat(1'b1, 4'b0000, 64'h1122_CEAB_0000_CDAB);

        // Gaps: outputs hold between accepted beats
        beat(1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
        check("hold1_data_a", adc_data_a, 64'hABCE_9697_ABCD_6677);
        check("hold1_data_b", adc_data_b, 64'hABCC_9694_ABCC_6674);
        beat(1'b0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
        check("hold2_or_b", 64'(adc_or_b), 64'(4'b0111));
        push(64'h0000_2211_0000_0000, 64'h0000_2210_0000_0000, 4'b0100);
        beat(1'b1, 4'b0000, 64'h0000_0000_0000_0000);
        beat(1'b0, 4'b0000, 64'd0);

        // Mismatch with pattern 0100, then relock on pattern 0101
        beat(1'b1, 4'b0001, 64'h1234_5678_9ABC_DEF0);
        check_lock("mismatch2", 1'b0, 16'd2);
        beat(1'b1, 4'b0101, 64'h8877_6655_4433_2211);
        check_lock("relock_0101", 1'b1, 16'd2);
        push(64'h7788_5566_3344_1122, 64'h7788_5564_3344_1120, 4'b0000);
        beat(1'b1, 4'b0101, 64'h0000_0000_0000_0000);
        beat(1'b1, 4'b0001, 64'h0000_0000_0000_0000);
        check_lock("mismatch3", 1'b0, 16'd3);
        for (int k = 0; k < 2; k++) begin
            beat(1'b1, 4'b0001, 64'h0101_0101_0101_0101);
            beat(1'b1, 4'b0010, 64'h0202_0202_0202_0202);
        end
        check_lock("mismatch5", 1'b0, 16'd5);
        beat(1'b1, 4'b0001, 64'h0303_0303_0303_0303);
        check_lock("locked_cnt5", 1'b1, 16'd5);

        // Reset in the middle of the stream overrides an otherwise accepted beat
        rst = 1'b1;
        beat(1'b1, 4'b0000, 64'h0404_0404_0404_0404);
        rst = 1'b0;
        check("rst_data_a", adc_data_a, 64'd0);
        check("rst_data_b", adc_data_b, 64'd0);
        check("rst_or_b", 64'(adc_or_b), 64'd0);
        check_lock("rst_mid", 1'b0, 16'd0);

        // Ordinary operation after reset
        beat(1'b1, 4'b0000, 64'h0505_0505_0505_0505);
        beat(1'b1, 4'b0001, 64'h0123_4567_DEAD_BEEF);
        check_lock("post_rst_lock", 1'b1, 16'd0);
        push(64'h2301_6745_ADDE_EFBE, 64'h2300_6744_ADDC_EFBC, 4'b1100);
        beat(1'b1, 4'b0000, 64'h0000_0000_0000_0000);
        beat(1'b0, 4'b0000, 64'd0);
        beat(1'b0, 4'b0000, 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
